// File: rtl/tx_ctrl.sv
// Transmit controller: one-block buffer in front of the 16B-in/8B-out output shift
// register, sequencing its load/shift strobes and metering beats with valid/ready/last.
module tx_ctrl #(
   parameter int NUM_BYTES_IN  = 16,
   parameter int NUM_BYTES_OUT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      blk_valid,
   input  logic [8*NUM_BYTES_IN-1:0] blk_data,
   output logic                      blk_ready,
   output logic [8*NUM_BYTES_IN-1:0] sr_data,
   output logic                      sr_load,
   output logic                      sr_shift,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      tx_last,
   output logic [7:0]                blk_count,
   output logic                      busy
);
   localparam int BEATS = NUM_BYTES_IN / NUM_BYTES_OUT;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                    state;
   logic                      hold_full;
   logic [8*NUM_BYTES_IN-1:0] buf_q;
   logic [CNT_W-1:0]          beat_cnt;
   logic                      beat_done;
   logic                      at_last;
   logic                      accept;

   assign beat_done = (state == SEND) && tx_ready;
   assign at_last   = (beat_cnt == LAST_BEAT);
   assign accept    = blk_valid && blk_ready;

   // Strobes follow the downstream handshake in the same cycle, so they stay
   // combinational; everything they depend on besides tx_ready is a flop.
   assign sr_load   = hold_full && ((state == IDLE) || (beat_done && at_last));
   assign sr_shift  = beat_done && !at_last;
   assign blk_ready = !hold_full;
   assign busy      = hold_full || (state != IDLE);
   assign sr_data   = buf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hold_full <= 1'b0;
         buf_q     <= '0;
         beat_cnt  <= '0;
         blk_count <= 8'd0;
         tx_valid  <= 1'b0;
         tx_last   <= 1'b0;
      end else begin
         // Accept and drain are exclusive: blk_ready is low whenever sr_load can fire.
         if (accept) begin
            buf_q     <= blk_data;
            hold_full <= 1'b1;
         end else if (sr_load) begin
            hold_full <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (hold_full) begin
                  state    <= SEND;
                  beat_cnt <= '0;
                  tx_valid <= 1'b1;
                  tx_last  <= (LAST_BEAT == '0);
               end
            end
            SEND: begin
               if (tx_ready) begin
                  if (!at_last) begin
                     beat_cnt <= beat_cnt + 1'b1;
                     tx_last  <= ((beat_cnt + 1'b1) == LAST_BEAT);
                  end else begin
                     blk_count <= blk_count + 8'd1;
                     if (hold_full) begin
                        beat_cnt <= '0;
                        tx_last  <= (LAST_BEAT == '0);
                     end else begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tx_ctrl.sv
// Bench for tx_ctrl: directed latency/stall/reset/wrap cases plus a random phase,
// all beats checked against a queue of accepted blocks through a modelled shift register.
module tb_tx_ctrl;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         blk_valid = 1'b0;
   logic [127:0] blk_data = '0;
   logic         blk_ready;
   logic [127:0] sr_data;
   logic         sr_load, sr_shift, tx_valid, tx_last, busy;
   logic         tx_ready = 1'b0;
   logic [7:0]   blk_count;

   int total = 0;
   int bad   = 0;

   tx_ctrl dut (
      .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data),
      .blk_ready(blk_ready), .sr_data(sr_data), .sr_load(sr_load), .sr_shift(sr_shift),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
      .blk_count(blk_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Downstream shift register: 16 bytes in, top 8 bytes out.
   logic [127:0] sr_m = '0;
   logic [63:0]  sr_out;
   assign sr_out = sr_m[127:64];
   always @(posedge clk) begin
      if (sr_load)       sr_m <= sr_data;
      else if (sr_shift) sr_m <= {sr_m[63:0], 64'h0};
   end

   // Reference: every accepted block becomes two beats, high half first.
   logic [64:0]  beat_q[$];
   logic [7:0]   exp_cnt  = 8'd0;
   logic [127:0] last_acc = '0;
   always @(negedge clk) begin
      if (rst) begin
         beat_q.delete();
         exp_cnt  = 8'd0;
         last_acc = '0;
      end else begin
         chk("cnt", blk_count, exp_cnt);
         chk("sr_data", sr_data, last_acc);
         chk("excl", sr_load & sr_shift, 0);
         chk("last_no_vld", tx_last & ~tx_valid, 0);
         if (tx_valid) begin
            if (beat_q.size() == 0) chk("spurious_beat", 1, 0);
            else begin
               chk("beat", sr_out, beat_q[0][63:0]);
               chk("last", tx_last, beat_q[0][64]);
               if (tx_ready) begin
                  if (beat_q[0][64]) exp_cnt++;
                  void'(beat_q.pop_front());
               end
            end
         end
         if (blk_valid && blk_ready) begin
            beat_q.push_back({1'b0, blk_data[127:64]});
            beat_q.push_back({1'b1, blk_data[63:0]});
            last_acc = blk_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while (busy && c < budget) begin
         tick();
         c++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic send_blocks(input int n);
      int acc = 0;
      int c = 0;
      logic pre;
      blk_valid = 1'b1;
      blk_data  = {$urandom, $urandom, $urandom, $urandom};
      while (acc < n && c < 4 * n + 20) begin
         pre = blk_ready;
         tick();
         c++;
         if (pre) begin
            acc++;
            blk_data = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      blk_valid = 1'b0;
      chk("send_timeout", acc, n);
      wait_idle(20);
   endtask

   localparam logic [127:0] K  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] A  = 128'hA5A5A5A5_01010101_5A5A5A5A_02020202;
   localparam logic [127:0] B0 = 128'h10000000_00000001_20000000_00000002;
   localparam logic [127:0] B1 = 128'h30000000_00000003_40000000_00000004;
   localparam logic [127:0] S0 = 128'hDEADBEEF_00000000_CAFEF00D_11111111;
   localparam logic [127:0] S1 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
   localparam logic [127:0] S2 = 128'hFFFF0000_FFFF0000_0000FFFF_0000FFFF;

   initial begin
      logic pre;
      int   n_acc, run, max_run, c;
      logic [127:0] tmp;

      // Reset values while rst is held
      #2;
      chk("rst_load", sr_load, 0);
      chk("rst_shift", sr_shift, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_last", tx_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", blk_count, 0);
      chk("rst_ready", blk_ready, 1);
      chk("rst_data", sr_data, 0);
      tick();
      rst = 1'b0;

      // Reset after beat 0 handshake discards the partial block
      tx_ready = 1'b1;
      blk_valid = 1'b1; blk_data = A;
      tick();
      blk_valid = 1'b0;
      tick();
      chk("mid_beat0", sr_out, A[127:64]);
      tick();
      rst = 1'b1;
      #1;
      chk("mid_valid", tx_valid, 0);
      chk("mid_last", tx_last, 0);
      chk("mid_busy", busy, 0);
      chk("mid_ready", blk_ready, 1);
      chk("mid_cnt", blk_count, 0);
      chk("mid_shift", sr_shift, 0);
      tick();
      rst = 1'b0;

      // Single block, exact cycle timing
      blk_valid = 1'b1; blk_data = K;
      tick();
      blk_valid = 1'b0;
      chk("s_load", sr_load, 1);
      chk("s_ready0", blk_ready, 0);
      chk("s_busy", busy, 1);
      chk("s_vld0", tx_valid, 0);
      tick();
      chk("s_vld1", tx_valid, 1);
      chk("s_last1", tx_last, 0);
      chk("s_shift1", sr_shift, 1);
      chk("s_beat1", sr_out, 64'h0011223344556677);
      chk("s_ready1", blk_ready, 1);
      tick();
      chk("s_vld2", tx_valid, 1);
      chk("s_last2", tx_last, 1);
      chk("s_beat2", sr_out, 64'h8899AABBCCDDEEFF);
      chk("s_noload", sr_load | sr_shift, 0);
      tick();
      chk("s_vld3", tx_valid, 0);
      chk("s_cnt", blk_count, 1);
      chk("s_idle", busy, 0);

      // Back-to-back blocks: four beats without a gap
      blk_valid = 1'b1; blk_data = B0;
      n_acc = 0; run = 0; max_run = 0;
      for (int i = 0; i < 12; i++) begin
         pre = blk_ready;
         if (tx_valid && tx_last && run == 1) chk("b2b_load", sr_load, 1);
         if (tx_valid) run++; else run = 0;
         if (run > max_run) max_run = run;
         tick();
         if (pre && blk_valid) begin
            n_acc++;
            if (n_acc == 2) blk_valid = 1'b0; else blk_data = B1;
         end
      end
      chk("b2b_run", max_run, 4);
      chk("b2b_cnt", blk_count, 3);

      // Downstream stall on beat 0
      tx_ready = 1'b0;
      blk_valid = 1'b1; blk_data = S0;
      tick();
      blk_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("st_vld", tx_valid, 1);
         chk("st_shift", sr_shift, 0);
         chk("st_data", sr_out, S0[127:64]);
         chk("st_ready", blk_ready, 1);
         tick();
      end
      blk_valid = 1'b1; blk_data = S1;
      tick();
      blk_data = S2;
      for (int i = 0; i < 4; i++) begin
         chk("ovw_ready", blk_ready, 0);
         chk("ovw_data", sr_data, S1);
         tick();
      end
      tx_ready = 1'b1;
      c = 0;
      while (!sr_load && c < 20) begin tick(); c++; end
      chk("st_load_seen", sr_load, 1);
      tick();
      chk("rdy_after_load", blk_ready, 1);
      tick();
      blk_valid = 1'b0;
      chk("ovw_new", sr_data, S2);
      wait_idle(20);
      chk("st_cnt", blk_count, 6);

      // Counter wrap at 256 blocks
      do_reset();
      send_blocks(255);
      chk("wrap_255", blk_count, 255);
      send_blocks(1);
      chk("wrap_0", blk_count, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         blk_valid = ($urandom_range(0, 99) < 60);
         tmp = {$urandom, $urandom, $urandom, $urandom};
         blk_data = tmp;
         tx_ready = ($urandom_range(0, 99) < 70);
         tick();
      end
      blk_valid = 1'b0;
      tx_ready = 1'b1;
      wait_idle(40);
      tick();
      chk("q_empty", beat_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
